fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
Round-robin, burst-capable arbiter that shares the push side of one synchronous `fifo` instance among NUM_REQ requesters.
- Each requester presents a valid/ready stream.
- The winner keeps ownership for up to MAX_BURST beats.
- Granted beats go to the FIFO's push/data_in through one register stage, with a source tag alongside.
- The block respects the FIFO's alFull/full flags.
- It sits between the AFU command/response generators and the shared FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 32, data width per requester; equals the downstream FIFO WIDTH.
- REQ_BITS, $clog2(NUM_REQ), width of the source id.
- MAX_BURST, 8, maximum consecutive beats per grant (1..256).
- CNT_W, 16, width of each per-requester beat counter (optional feature only).

Ports:
- clock  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i has a beat.
- req_data  in  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  bit i: beat i accepted this cycle when req_valid[i] is also high.
- fifo_alFull  in  1  downstream FIFO almost-full.
- fifo_full  in  1  downstream FIFO full.
- fifo_push  out  1  registered push to the FIFO.
- fifo_data_in  out  WIDTH  registered push data.
- fifo_src_id  out  REQ_BITS  registered id of the pushing requester.
- arb_busy  out  1  high while state is GRANT.
- grant_cnt  out  NUM_REQ*CNT_W  per-requester accepted-beat counters (see Optional Feature).

Behaviour:
- Reset (rst=1 at a posedge), which overrides everything including mid-burst:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, beat_cnt=0.
  - fifo_push=0, fifo_data_in=0, fifo_src_id=0, arb_busy=0, req_ready=0.
  - Any in-flight burst is abandoned; no partial push is emitted after reset.
- Stall condition: stall = fifo_alFull | fifo_full.
- IDLE state:
  - req_ready=0.
  - If any req_valid and !stall: owner <= first i with req_valid[i], scanning (last_owner+1) mod NUM_REQ upward with wrap; beat_cnt <= 0; state <= GRANT.
  - Otherwise remain in IDLE.
- GRANT state:
  - req_ready[owner] = !stall; all other req_ready bits = 0.
  - xfer = req_valid[owner] & req_ready[owner].
  - On xfer: beat_cnt <= beat_cnt+1.
  - Return to IDLE, with last_owner <= owner, when either:
    - req_valid[owner]=0 in GRANT with stall=0 (an empty cycle ends the burst), or
    - xfer and beat_cnt==MAX_BURST-1.
  - During stall, ownership is held (no re-arbitration) and beat_cnt is frozen.
- Arbitration gap: one IDLE cycle always separates two grants, giving at most MAX_BURST beats per MAX_BURST+1 cycles per grant.
- Output stage (one cycle latency from xfer):
  - fifo_push <= xfer.
  - fifo_data_in <= req_data[owner], loaded only on xfer; otherwise the value is held.
  - fifo_src_id <= owner, loaded only on xfer.
- Downstream sizing: the FIFO's own push register adds one more cycle. The FIFO HEADROOM must be ≥3 so that beats already in flight when alFull rises cannot overflow it.
- req_ready depends combinationally on fifo_alFull/fifo_full and registered state only; it never depends on req_valid.
- Simultaneous requests are resolved purely by rotation. A requester that deasserts valid while not owner loses nothing.
- arb_busy = (state==GRANT).
- beat_cnt width is $clog2(MAX_BURST+1); it never wraps because the exit at MAX_BURST-1 bounds it.

Optional Feature:
- Macro: FIFO_ARB_GRANT_CNT_EN.
- Defined:
  - Each grant_cnt[i] increments by 1 on every xfer with owner==i.
  - Counters saturate at 2^CNT_W-1 and are cleared to 0 by rst.
- Undefined:
  - No counter logic is built.
  - grant_cnt stays a port, tied to all zeros.

Test Plan:
- Reset, then single requester: req_valid=4'b0001 with data 0xA0..0xA3, 4 beats, MAX_BURST=8 → grant on cycle 2. Pushes 0xA0..0xA3 appear one cycle after each xfer with src_id=0. An IDLE return follows when valid drops.
- All four requesters valid continuously, MAX_BURST=2, stall=0 → grant order 0,1,2,3,0. Each owner gets exactly 2 beats. One-cycle gap between grants. Never two req_ready bits high at once.
- fifo_alFull asserted mid-burst after beat 3 for 5 cycles → req_ready[owner]=0 for those 5 cycles with no push. The same owner resumes with beat 4 and the burst still totals MAX_BURST.
- rst pulsed in GRANT at beat 2 of requester 2 → next cycle all outputs are 0 and state is IDLE. Next arbitration with all valid picks requester 0. No stray fifo_push.
- With FIFO_ARB_GRANT_CNT_EN, CNT_W=4: requester 1 sends 20 beats → grant_cnt[1] saturates at 15 and the others stay 0. Without the macro, grant_cnt reads 0 throughout.
- Integration with `fifo` (DEPTH=32, HEADROOM=16): 4 requesters flood while pop=0 → alFull stops pushes, full never asserts, no beat lost or duplicated. Pop order matches push order with correct src_id.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-capable arbiter feeding the push side
// of one shared synchronous FIFO. The winner owns the FIFO for up to
// MAX_BURST beats. Granted beats are registered once before reaching the FIFO,
// and each beat carries its source id.
// Optional build macro FIFO_ARB_GRANT_CNT_EN adds per-requester saturating
// accepted-beat counters on grant_cnt. Without it, grant_cnt is tied to zero.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int REQ_BITS  = $clog2(NUM_REQ),
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_alFull,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [REQ_BITS-1:0]      fifo_src_id,
  output logic                     arb_busy,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);

  localparam int                  BC_W       = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]     BC_LAST    = BC_W'(MAX_BURST - 1);
  localparam logic [REQ_BITS-1:0] OWNER_LAST = REQ_BITS'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state, w_state_nxt;
  logic [REQ_BITS-1:0] r_owner, w_owner_nxt;
  logic [REQ_BITS-1:0] r_last_owner, w_last_owner_nxt;
  logic [BC_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;

  logic                w_stall;
  logic                w_xfer;
  logic                w_pick_vld;
  logic [REQ_BITS-1:0] w_pick;
  logic [NUM_REQ-1:0]  w_ready;
  logic [WIDTH-1:0]    w_req_data [NUM_REQ];

  logic                r_vld_p1;
  logic [WIDTH-1:0]    r_data_p1;
  logic [REQ_BITS-1:0] r_src_p1;

  assign w_stall = fifo_alFull | fifo_full;

  // Unpack the flat requester data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_data[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority: scan requesters above last_owner first, then wrap to 0..last_owner.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_pick_vld && req_valid[i] && (i > int'(r_last_owner))) begin
        w_pick_vld = 1'b1;
        w_pick     = REQ_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_pick_vld && req_valid[i] && (i <= int'(r_last_owner))) begin
        w_pick_vld = 1'b1;
        w_pick     = REQ_BITS'(i);
      end
    end
  end

  // FSM next state, grant/ready generation and burst bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_ready          = '0;
    w_xfer           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld && !w_stall) begin
          w_owner_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_GRANT;
        end
      end
      S_GRANT: begin
        // ready never looks at req_valid, so a stall freezes the burst in place
        w_ready[r_owner] = !w_stall;
        w_xfer           = req_valid[r_owner] & !w_stall;
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + BC_W'(1);
          if (r_beat_cnt == BC_LAST) begin
            w_state_nxt      = S_IDLE;
            w_last_owner_nxt = r_owner;
          end
        end else if (!w_stall && !req_valid[r_owner]) begin
          w_state_nxt      = S_IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arbiter state registers; reset abandons any burst in progress.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OWNER_LAST;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  // Stage p0 -> p1: register the accepted beat toward the FIFO; data and id hold between beats.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_src_p1  <= '0;
    end else begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_data_p1 <= w_req_data[r_owner];
        r_src_p1  <= r_owner;
      end
    end
  end

  assign req_ready    = w_ready;
  assign fifo_push    = r_vld_p1;
  assign fifo_data_in = r_data_p1;
  assign fifo_src_id  = r_src_p1;
  assign arb_busy     = (r_state == S_GRANT);

`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] r_grant_cnt [NUM_REQ];

  // Count accepted beats per owner, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= '0;
      end
    end else if (w_xfer && (r_grant_cnt[r_owner] != {CNT_W{1'b1}})) begin
      r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + CNT_W'(1);
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = r_grant_cnt[i];
    end
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: a vector table of {inputs, expected
// outputs} per cycle, plus hand-written sequences for counter saturation and a
// FIFO flood with a behavioural FIFO occupancy model.
module tb_fifo_push_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic         alf, full;

  logic [3:0]  rdy8, rdy2;
  logic        push8, push2, busy8, busy2;
  logic [31:0] data8, data2;
  logic [1:0]  src8, src2;
  logic [15:0] gcnt8, gcnt2;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(8), .CNT_W(4)) u8 (
    .clock(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy8),
    .fifo_alFull(alf), .fifo_full(full), .fifo_push(push8), .fifo_data_in(data8),
    .fifo_src_id(src8), .arb_busy(busy8), .grant_cnt(gcnt8));

  fifo_push_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_BURST(2), .CNT_W(4)) u2 (
    .clock(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy2),
    .fifo_alFull(alf), .fifo_full(full), .fifo_push(push2), .fifo_data_in(data2),
    .fifo_src_id(src2), .arb_busy(busy2), .grant_cnt(gcnt2));

  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic         alf;
    logic         full;
    logic [127:0] data;
    logic         dut;    // 0: MAX_BURST=8 instance, 1: MAX_BURST=2 instance
    logic         chk;
    logic [3:0]   ready;
    logic         push;
    logic [31:0]  fdata;
    logic [1:0]   src;
    logic         busy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } ent_t;

  vec_t tv[$];
  ent_t fq[$];

  function automatic vec_t v(input logic r, input logic [3:0] vl, input logic a, input logic f,
                             input logic [127:0] d, input logic du, input logic c,
                             input logic [3:0] rd, input logic p, input logic [31:0] fd,
                             input logic [1:0] s, input logic b);
    vec_t t;
    t.rst = r; t.valid = vl; t.alf = a; t.full = f; t.data = d; t.dut = du; t.chk = c;
    t.ready = rd; t.push = p; t.fdata = fd; t.src = s; t.busy = b;
    return t;
  endfunction

  function automatic logic [127:0] at2(input logic [31:0] x);
    return {32'h0, x, 64'h0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; alf = 1'b0; full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [127:0] DB = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] DE = 128'h000000E3_000000E2_000000E1_000000E0;

  initial begin
    int acc, pushes, maxq, total;
    int seq [4];
    int exp_seq [4];
    logic [3:0] rdy_s;
    logic [1:0] src_s;
    logic [31:0] data_s;
    logic push_s, busy_s;
    ent_t e;

    rst = 1'b1; req_valid = '0; req_data = '0; alf = 1'b0; full = 1'b0;

    // single requester 0, 4 beats, MAX_BURST=8
    tv.push_back(v(1, 4'h0, 0, 0, 128'h0,  0, 0, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h1, 0, 0, 128'hA0, 0, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h1, 0, 0, 128'hA0, 0, 1, 4'h1, 0, 32'h0,  2'd0, 1));
    tv.push_back(v(0, 4'h1, 0, 0, 128'hA1, 0, 1, 4'h1, 1, 32'hA0, 2'd0, 1));
    tv.push_back(v(0, 4'h1, 0, 0, 128'hA2, 0, 1, 4'h1, 1, 32'hA1, 2'd0, 1));
    tv.push_back(v(0, 4'h1, 0, 0, 128'hA3, 0, 1, 4'h1, 1, 32'hA2, 2'd0, 1));
    tv.push_back(v(0, 4'h0, 0, 0, 128'hA3, 0, 1, 4'h1, 1, 32'hA3, 2'd0, 1));
    tv.push_back(v(0, 4'h0, 0, 0, 128'hA3, 0, 1, 4'h0, 0, 32'hA3, 2'd0, 0));
    // all four valid, MAX_BURST=2: grants 0,1,2,3,0 with one idle cycle between
    tv.push_back(v(1, 4'h0, 0, 0, DB, 1, 0, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h1, 0, 32'h0,  2'd0, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h1, 1, 32'hB0, 2'd0, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 1, 32'hB0, 2'd0, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h2, 0, 32'hB0, 2'd0, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h2, 1, 32'hB1, 2'd1, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 1, 32'hB1, 2'd1, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h4, 0, 32'hB1, 2'd1, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h4, 1, 32'hB2, 2'd2, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 1, 32'hB2, 2'd2, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h8, 0, 32'hB2, 2'd2, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h8, 1, 32'hB3, 2'd3, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 1, 32'hB3, 2'd3, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h1, 0, 32'hB3, 2'd3, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h1, 1, 32'hB0, 2'd0, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DB, 1, 1, 4'h0, 1, 32'hB0, 2'd0, 0));
    // requester 2, alFull for 5 cycles after beat 3, burst still totals 8
    tv.push_back(v(1, 4'h0, 0, 0, 128'h0,     0, 0, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD0), 0, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD0), 0, 1, 4'h4, 0, 32'h0,  2'd0, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD1), 0, 1, 4'h4, 1, 32'hD0, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD2), 0, 1, 4'h4, 1, 32'hD1, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 1, 0, at2(32'hD3), 0, 1, 4'h0, 1, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 1, 0, at2(32'hD3), 0, 1, 4'h0, 0, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 1, 0, at2(32'hD3), 0, 1, 4'h0, 0, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 1, 0, at2(32'hD3), 0, 1, 4'h0, 0, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 1, 0, at2(32'hD3), 0, 1, 4'h0, 0, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD3), 0, 1, 4'h4, 0, 32'hD2, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD4), 0, 1, 4'h4, 1, 32'hD3, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD5), 0, 1, 4'h4, 1, 32'hD4, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD6), 0, 1, 4'h4, 1, 32'hD5, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD7), 0, 1, 4'h4, 1, 32'hD6, 2'd2, 1));
    tv.push_back(v(0, 4'h4, 0, 0, at2(32'hD7), 0, 1, 4'h0, 1, 32'hD7, 2'd2, 0));
    tv.push_back(v(0, 4'h0, 0, 0, at2(32'hD7), 0, 1, 4'h4, 0, 32'hD7, 2'd2, 1));
    tv.push_back(v(0, 4'h0, 0, 0, at2(32'hD7), 0, 1, 4'h0, 0, 32'hD7, 2'd2, 0));
    // full blocks arbitration in IDLE; reset mid-burst of requester 2, then requester 0 wins
    tv.push_back(v(1, 4'h0, 0, 0, DE, 0, 0, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h4, 0, 1, DE, 0, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h4, 0, 0, DE, 0, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'h4, 0, 0, DE, 0, 1, 4'h4, 0, 32'h0,  2'd0, 1));
    tv.push_back(v(0, 4'h4, 0, 0, DE, 0, 1, 4'h4, 1, 32'hE2, 2'd2, 1));
    tv.push_back(v(1, 4'h4, 0, 0, DE, 0, 1, 4'h4, 1, 32'hE2, 2'd2, 1));
    tv.push_back(v(0, 4'hF, 0, 0, DE, 0, 1, 4'h0, 0, 32'h0,  2'd0, 0));
    tv.push_back(v(0, 4'hF, 0, 0, DE, 0, 1, 4'h1, 0, 32'h0,  2'd0, 1));
    tv.push_back(v(0, 4'h0, 0, 0, DE, 0, 1, 4'h1, 1, 32'hE0, 2'd0, 1));
    tv.push_back(v(0, 4'h0, 0, 0, DE, 0, 1, 4'h0, 0, 32'hE0, 2'd0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; req_valid = tv[i].valid; alf = tv[i].alf; full = tv[i].full;
      req_data = tv[i].data;
      #1;
      if (tv[i].dut) begin
        rdy_s = rdy2; push_s = push2; data_s = data2; src_s = src2; busy_s = busy2;
      end else begin
        rdy_s = rdy8; push_s = push8; data_s = data8; src_s = src8; busy_s = busy8;
      end
      if (tv[i].chk) begin
        check($sformatf("v%0d req_ready", i), 32'(rdy_s), 32'(tv[i].ready));
        check($sformatf("v%0d fifo_push", i), 32'(push_s), 32'(tv[i].push));
        check($sformatf("v%0d fifo_data_in", i), data_s, tv[i].fdata);
        check($sformatf("v%0d fifo_src_id", i), 32'(src_s), 32'(tv[i].src));
        check($sformatf("v%0d arb_busy", i), 32'(busy_s), 32'(tv[i].busy));
`ifndef FIFO_ARB_GRANT_CNT_EN
        check($sformatf("v%0d grant_cnt", i), 32'(tv[i].dut ? gcnt2 : gcnt8), 32'h0);
`endif
      end
    end

    // requester 1 sends 20 beats; counter (CNT_W=4) saturates at 15
    pulse_reset();
    acc = 0; pushes = 0;
    req_data = {32'h0, 32'h0, 32'h0000C0DE, 32'h0};
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      req_valid = (acc < 20) ? 4'h2 : 4'h0;
      #1;
      if (req_valid[1] && rdy8[1]) acc++;
      if (push8) pushes++;
    end
    check("burst20 accepted", 32'(acc), 32'd20);
    check("burst20 pushes", 32'(pushes), 32'd20);
`ifdef FIFO_ARB_GRANT_CNT_EN
    check("grant_cnt saturate", 32'(gcnt8), 32'h0000_00F0);
`else
    check("grant_cnt tied off", 32'(gcnt8), 32'h0);
`endif

    // flood: behavioural FIFO DEPTH=32, HEADROOM=16, never popped
    pulse_reset();
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    maxq = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      req_valid = (c < 70) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = (i << 16) | seq[i];
      alf  = (fq.size() >= 16);
      full = (fq.size() >= 32);
      #1;
      for (int i = 0; i < 4; i++) if (req_valid[i] && rdy8[i]) seq[i]++;
      if (push8) begin
        e.d = data8; e.s = src8;
        fq.push_back(e);
      end
      if (fq.size() > maxq) maxq = fq.size();
    end
    total = seq[0] + seq[1] + seq[2] + seq[3];
    check("flood beats pushed", 32'(fq.size()), 32'(total));
    check("flood never full", 32'(maxq < 32), 32'd1);
    check("flood alFull limits", 32'(maxq <= 18), 32'd1);
    while (fq.size() > 0) begin
      e = fq.pop_front();
      check("flood order", e.d, (32'(e.s) << 16) | 32'(exp_seq[e.s]));
      exp_seq[e.s]++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
